pitch_tracker: RTL and testbench

PITCH_TRACKER -- requirements
Module: pitch_tracker

---
 rtl/pitch_pkg.sv | 15 +
 rtl/seq_divider.sv | 83 ++++++++
 rtl/pitch_tracker.sv | 181 ++++++++++++++++++
 tb/tb_pitch_tracker.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pitch_pkg.sv
// Shared types and sizing for the pitch tracker: FSM state encoding,
// default sample/phase widths and the period counter width.
package pitch_pkg;

    localparam int AUDIO_W_DEF = 11;
    localparam int PHASE_W_DEF = 32;
    localparam int CNT_W       = 12;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        DONE   = 2'd2
    } state_e;

endpackage

// File: rtl/seq_divider.sv
// Restoring divider computing floor(2^Q_W / divisor), one quotient bit per clock.
// A divisor of 1 naturally produces all ones, i.e. the saturated result.
module seq_divider #(
    parameter int DIV_W = 12,
    parameter int Q_W   = 32
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             start_in,
    input  logic             abort_in,
    input  logic [DIV_W-1:0] divisor_in,
    output logic             busy_out,
    output logic             done_out,
    output logic [Q_W-1:0]   quotient_out
);

    localparam int IT_W = $clog2(Q_W + 1);

    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [IT_W-1:0]  iter_q, iter_d;
    logic [DIV_W-1:0] divisor_q, divisor_d;
    logic [DIV_W-1:0] rem_q, rem_d;
    logic [Q_W-1:0]   quot_q, quot_d;
    logic [DIV_W:0]   rem_shift;

    always_comb begin
        busy_d    = busy_q;
        done_d    = 1'b0;
        iter_d    = iter_q;
        divisor_d = divisor_q;
        rem_d     = rem_q;
        quot_d    = quot_q;
        rem_shift = {rem_q, 1'b0};
        if (abort_in) begin
            busy_d = 1'b0;
        end else if (start_in) begin
            // The leading 1 of the dividend 2^Q_W is preloaded into the remainder;
            // the remaining Q_W dividend bits are all zero.
            busy_d    = 1'b1;
            iter_d    = '0;
            divisor_d = divisor_in;
            rem_d     = {{(DIV_W-1){1'b0}}, 1'b1};
            quot_d    = '0;
        end else if (busy_q) begin
            if (rem_shift >= {1'b0, divisor_q}) begin
                rem_d  = DIV_W'(rem_shift - {1'b0, divisor_q});
                quot_d = {quot_q[Q_W-2:0], 1'b1};
            end else begin
                rem_d  = rem_shift[DIV_W-1:0];
                quot_d = {quot_q[Q_W-2:0], 1'b0};
            end
            iter_d = iter_q + 1'b1;
            if (iter_q == IT_W'(Q_W - 1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            iter_q <= '0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
            iter_q <= iter_d;
        end
    end

    always_ff @(posedge clk_in) begin
        divisor_q <= divisor_d;
        rem_q     <= rem_d;
        quot_q    <= quot_d;
    end

    assign busy_out     = busy_q;
    assign done_out     = done_q;
    assign quotient_out = quot_q;

endmodule

// File: rtl/pitch_tracker.sv
// Zero-crossing pitch tracker producing a synthesizer phase increment.
// Define PITCH_TRACKER_SMOOTH_EN to average the last two accepted periods.
module pitch_tracker
    import pitch_pkg::*;
#(
    parameter int AUDIO_W    = AUDIO_W_DEF,
    parameter int PHASE_W    = PHASE_W_DEF,
    parameter int MIDPOINT   = 1024,
    parameter int HYST       = 16,
    parameter int MIN_PERIOD = 8,
    parameter int MAX_PERIOD = 4095
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic [AUDIO_W-1:0] audio_in,
    input  logic               audio_valid_in,
    output logic [PHASE_W-1:0] phase_incr_out,
    output logic               phase_valid_out,
    output logic               locked_out
);

    localparam logic [AUDIO_W:0] HI_TH = (AUDIO_W+1)'(MIDPOINT + HYST);
    localparam logic [AUDIO_W:0] LO_TH = (AUDIO_W+1)'(MIDPOINT - HYST);

    logic [AUDIO_W-1:0] smp_q;
    logic               smp_vld_q;
    logic               armed_q, armed_d;
    logic               running_q, running_d;
    logic [CNT_W-1:0]   count_q, count_d;
    state_e             state_q, state_d;
    logic [PHASE_W-1:0] incr_q, incr_d;
    logic               locked_q, locked_d;

    logic               crossing;
    logic               timeout;
    logic               accept;
    logic [CNT_W-1:0]   divisor;
    logic               div_start, div_abort, div_busy, div_done;
    logic [PHASE_W-1:0] div_quot;

    // Input stage: one register on the sample and its strobe.
    always_ff @(posedge clk_in) begin
        smp_q <= audio_in;
    end

    always_comb begin
        crossing  = smp_vld_q && armed_q && ({1'b0, smp_q} >= HI_TH);
        // The count never exceeds MAX_PERIOD: reaching it without a crossing times out.
        timeout   = smp_vld_q && running_q && !crossing && (count_q == CNT_W'(MAX_PERIOD));
        accept    = crossing && running_q && (count_q >= CNT_W'(MIN_PERIOD))
                    && (state_q == IDLE) && !div_busy;
        armed_d   = armed_q;
        running_d = running_q;
        count_d   = count_q;
        if (smp_vld_q) begin
            if (crossing) begin
                armed_d = 1'b0;
            end else if ({1'b0, smp_q} <= LO_TH) begin
                armed_d = 1'b1;
            end
        end
        if (crossing) begin
            running_d = 1'b1;
            count_d   = CNT_W'(1);
        end else if (timeout) begin
            running_d = 1'b0;
            count_d   = '0;
        end else if (smp_vld_q && running_q) begin
            count_d = count_q + 1'b1;
        end
    end

`ifdef PITCH_TRACKER_SMOOTH_EN
    logic [CNT_W-1:0] prev_q, prev_d;
    logic             have_prev_q, have_prev_d;
    logic [CNT_W:0]   pair_sum;

    always_comb begin
        pair_sum    = {1'b0, count_q} + {1'b0, prev_q};
        divisor     = have_prev_q ? pair_sum[CNT_W:1] : count_q;
        prev_d      = prev_q;
        have_prev_d = have_prev_q;
        if (accept) begin
            prev_d      = count_q;
            have_prev_d = 1'b1;
        end
        if (timeout) begin
            have_prev_d = 1'b0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            have_prev_q <= 1'b0;
        end else begin
            have_prev_q <= have_prev_d;
        end
    end

    always_ff @(posedge clk_in) begin
        prev_q <= prev_d;
    end
`else
    assign divisor = count_q;
`endif

    always_comb begin
        state_d   = state_q;
        div_start = 1'b0;
        div_abort = 1'b0;
        incr_d    = incr_q;
        locked_d  = locked_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = DIVIDE;
                    div_start = 1'b1;
                end
            end
            DIVIDE: begin
                if (timeout) begin
                    state_d   = IDLE;
                    div_abort = 1'b1;
                end else if (div_done) begin
                    state_d  = DONE;
                    incr_d   = div_quot;
                    locked_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (timeout) begin
            incr_d   = '0;
            locked_d = 1'b0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            smp_vld_q <= 1'b0;
            armed_q   <= 1'b0;
            running_q <= 1'b0;
            count_q   <= '0;
            state_q   <= IDLE;
            incr_q    <= '0;
            locked_q  <= 1'b0;
        end else begin
            smp_vld_q <= audio_valid_in;
            armed_q   <= armed_d;
            running_q <= running_d;
            count_q   <= count_d;
            state_q   <= state_d;
            incr_q    <= incr_d;
            locked_q  <= locked_d;
        end
    end

    seq_divider #(
        .DIV_W (CNT_W),
        .Q_W   (PHASE_W)
    ) u_div (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .start_in     (div_start),
        .abort_in     (div_abort),
        .divisor_in   (divisor),
        .busy_out     (div_busy),
        .done_out     (div_done),
        .quotient_out (div_quot)
    );

    assign phase_incr_out  = incr_q;
    assign phase_valid_out = (state_q == DONE);
    assign locked_out      = locked_q;

endmodule

// File: tb/tb_pitch_tracker.sv
// Directed bench for pitch_tracker: locking, latency, timeout, short periods,
// reset during division and (with PITCH_TRACKER_SMOOTH_EN) period averaging.
module tb_pitch_tracker;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic [10:0] audio_in = 11'd0;
    logic        audio_valid_in = 1'b0;
    logic [31:0] phase_incr_out;
    logic        phase_valid_out;
    logic        locked_out;

    int n_vec = 0;
    int n_err = 0;
    int edge_cnt = 0;
    int pulse_cnt = 0;
    int last_pulse_edge = 0;
    int sent_edge = 0;

    pitch_tracker dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .audio_in        (audio_in),
        .audio_valid_in  (audio_valid_in),
        .phase_incr_out  (phase_incr_out),
        .phase_valid_out (phase_valid_out),
        .locked_out      (locked_out)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) edge_cnt <= edge_cnt + 1;

    always @(negedge clk_in) begin
        if (phase_valid_out) begin
            pulse_cnt       <= pulse_cnt + 1;
            last_pulse_edge <= edge_cnt;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    // One strobed sample every 'gap' clocks; sent_edge is the consuming edge.
    task automatic send(input logic [10:0] s, input int gap);
        @(posedge clk_in); #1;
        audio_in       = s;
        audio_valid_in = 1'b1;
        sent_edge      = edge_cnt + 1;
        @(posedge clk_in); #1;
        audio_valid_in = 1'b0;
        repeat (gap - 2) @(posedge clk_in);
    endtask

    task automatic send_n(input logic [10:0] s, input int n, input int gap);
        for (int i = 0; i < n; i++) send(s, gap);
    endtask

    task automatic do_reset;
        @(negedge clk_in);
        rst_in = 1'b0;
        repeat (3) @(negedge clk_in);
        rst_in = 1'b1;
    endtask

    task automatic test_reset;
        #2;
        rst_in = 1'b0;
        #1;
        n_vec++;
        if (phase_incr_out !== 32'd0) begin
            n_err++; $display("FAIL reset_incr: got %0d, expected 0", phase_incr_out);
        end
        n_vec++;
        if (phase_valid_out !== 1'b0) begin
            n_err++; $display("FAIL reset_valid: got %0b, expected 0", phase_valid_out);
        end
        n_vec++;
        if (locked_out !== 1'b0) begin
            n_err++; $display("FAIL reset_locked: got %0b, expected 0", locked_out);
        end
        repeat (3) @(negedge clk_in);
        rst_in = 1'b1;
    endtask

    task automatic test_square;
        int p0;
        do_reset();
        p0 = pulse_cnt;
        send(11'd948, 4);
        for (int k = 0; k < 3; k++) begin
            send_n(11'd1100, 50, 4);
            send_n(11'd948, 50, 4);
        end
        send(11'd1100, 4);
        send_n(11'd948, 12, 4);
        @(negedge clk_in);
        n_vec++;
        if (pulse_cnt - p0 !== 3) begin
            n_err++; $display("FAIL square_pulses: got %0d, expected 3", pulse_cnt - p0);
        end
        n_vec++;
        if (phase_incr_out !== 32'd42949672) begin
            n_err++; $display("FAIL square_incr: got %0d, expected 42949672", phase_incr_out);
        end
        n_vec++;
        if (locked_out !== 1'b1) begin
            n_err++; $display("FAIL square_locked: got %0b, expected 1", locked_out);
        end
    endtask

    task automatic test_latency;
        int p0;
        int close_edge;
        do_reset();
        p0 = pulse_cnt;
        send(11'd948, 4);
        for (int k = 0; k < 2; k++) begin
            send_n(11'd1100, 32, 4);
            send_n(11'd948, 32, 4);
        end
        send(11'd1100, 4);
        close_edge = sent_edge;
        send_n(11'd948, 10, 4);
        @(negedge clk_in);
        n_vec++;
        if (pulse_cnt - p0 !== 2) begin
            n_err++; $display("FAIL lat_pulses: got %0d, expected 2", pulse_cnt - p0);
        end
        n_vec++;
        if (last_pulse_edge - close_edge !== 34) begin
            n_err++; $display("FAIL lat_clocks: got %0d, expected 34", last_pulse_edge - close_edge);
        end
        n_vec++;
        if (phase_incr_out !== 32'd67108864) begin
            n_err++; $display("FAIL lat_incr: got %0d, expected 67108864", phase_incr_out);
        end
    endtask

    // Continues from test_latency: 10 non-crossing samples already follow the last crossing.
    task automatic test_timeout;
        int p0;
        p0 = pulse_cnt;
        for (int i = 0; i < 4084; i++) send((i % 2) ? 11'd1034 : 11'd1014, 2);
        repeat (3) @(negedge clk_in);
        n_vec++;
        if (locked_out !== 1'b1) begin
            n_err++; $display("FAIL to_early_locked: got %0b, expected 1", locked_out);
        end
        send(11'd1014, 2);
        repeat (3) @(negedge clk_in);
        n_vec++;
        if (locked_out !== 1'b0) begin
            n_err++; $display("FAIL to_locked: got %0b, expected 0", locked_out);
        end
        n_vec++;
        if (phase_incr_out !== 32'd0) begin
            n_err++; $display("FAIL to_incr: got %0d, expected 0", phase_incr_out);
        end
        n_vec++;
        if (pulse_cnt - p0 !== 0) begin
            n_err++; $display("FAIL to_pulses: got %0d, expected 0", pulse_cnt - p0);
        end
    endtask

    // Continues from test_timeout: detector armed, first-crossing behaviour active.
    task automatic test_short_period;
        int p0;
        p0 = pulse_cnt;
        send(11'd1100, 4);
        send_n(11'd948, 3, 4);
        send(11'd1100, 4);
        send_n(11'd1100, 46, 4);
        @(negedge clk_in);
        n_vec++;
        if (pulse_cnt - p0 !== 0) begin
            n_err++; $display("FAIL short_pulses: got %0d, expected 0", pulse_cnt - p0);
        end
        n_vec++;
        if (phase_incr_out !== 32'd0) begin
            n_err++; $display("FAIL short_incr: got %0d, expected 0", phase_incr_out);
        end
        send_n(11'd948, 53, 4);
        send(11'd1100, 4);
        send_n(11'd948, 12, 4);
        @(negedge clk_in);
        n_vec++;
        if (pulse_cnt - p0 !== 1) begin
            n_err++; $display("FAIL p100_pulses: got %0d, expected 1", pulse_cnt - p0);
        end
        n_vec++;
        if (phase_incr_out !== 32'd42949672) begin
            n_err++; $display("FAIL p100_incr: got %0d, expected 42949672", phase_incr_out);
        end
        n_vec++;
        if (locked_out !== 1'b1) begin
            n_err++; $display("FAIL p100_locked: got %0b, expected 1", locked_out);
        end
    endtask

    // Continues from test_short_period: 12 samples follow the last crossing.
    task automatic test_reset_mid_divide;
        int p0;
        p0 = pulse_cnt;
        send_n(11'd948, 87, 4);
        send(11'd1100, 4);
        repeat (5) @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        #1;
        n_vec++;
        if (phase_incr_out !== 32'd0) begin
            n_err++; $display("FAIL mid_rst_incr: got %0d, expected 0", phase_incr_out);
        end
        n_vec++;
        if (locked_out !== 1'b0) begin
            n_err++; $display("FAIL mid_rst_locked: got %0b, expected 0", locked_out);
        end
        n_vec++;
        if (phase_valid_out !== 1'b0) begin
            n_err++; $display("FAIL mid_rst_valid: got %0b, expected 0", phase_valid_out);
        end
        repeat (3) @(negedge clk_in);
        rst_in = 1'b1;
        repeat (40) @(negedge clk_in);
        n_vec++;
        if (pulse_cnt - p0 !== 0) begin
            n_err++; $display("FAIL mid_rst_pulses: got %0d, expected 0", pulse_cnt - p0);
        end
        send_n(11'd948, 5, 4);
        send(11'd1100, 4);
        send_n(11'd1100, 49, 4);
        send_n(11'd948, 50, 4);
        @(negedge clk_in);
        n_vec++;
        if (pulse_cnt - p0 !== 0) begin
            n_err++; $display("FAIL first_cross_pulses: got %0d, expected 0", pulse_cnt - p0);
        end
        n_vec++;
        if (locked_out !== 1'b0) begin
            n_err++; $display("FAIL first_cross_locked: got %0b, expected 0", locked_out);
        end
        send(11'd1100, 4);
        send_n(11'd948, 12, 4);
        @(negedge clk_in);
        n_vec++;
        if (pulse_cnt - p0 !== 1) begin
            n_err++; $display("FAIL relock_pulses: got %0d, expected 1", pulse_cnt - p0);
        end
        n_vec++;
        if (phase_incr_out !== 32'd42949672) begin
            n_err++; $display("FAIL relock_incr: got %0d, expected 42949672", phase_incr_out);
        end
        n_vec++;
        if (locked_out !== 1'b1) begin
            n_err++; $display("FAIL relock_locked: got %0b, expected 1", locked_out);
        end
    endtask

`ifdef PITCH_TRACKER_SMOOTH_EN
    task automatic test_smooth;
        do_reset();
        send(11'd948, 4);
        send_n(11'd1100, 50, 4);
        send_n(11'd948, 50, 4);
        send(11'd1100, 4);
        send_n(11'd1100, 29, 4);
        @(negedge clk_in);
        n_vec++;
        if (phase_incr_out !== 32'd42949672) begin
            n_err++; $display("FAIL smooth_first: got %0d, expected 42949672", phase_incr_out);
        end
        send_n(11'd948, 30, 4);
        send(11'd1100, 4);
        send_n(11'd948, 12, 4);
        @(negedge clk_in);
        n_vec++;
        if (phase_incr_out !== 32'd53687091) begin
            n_err++; $display("FAIL smooth_avg: got %0d, expected 53687091", phase_incr_out);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_square();
        test_latency();
        test_timeout();
        test_short_period();
        test_reset_mid_divide();
`ifdef PITCH_TRACKER_SMOOTH_EN
        test_smooth();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
